serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: DIFF = A - B - BIN over WIDTH cycles using one
// full-subtractor cell and a borrow flop; streams bits and delivers a parallel word.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_bit_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             diff_bit_q, diff_bit_d;
  logic             valid_q, valid_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;

  logic             d_bit;
  logic             brw_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == CW'(WIDTH - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != StIdle);
  end

  assign d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
  assign brw_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);

  always_comb begin
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_d      = res_q;
    diff_d     = diff_q;
    cnt_d      = cnt_q;
    brw_d      = brw_q;
    bout_d     = bout_q;
    diff_bit_d = 1'b0;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          brw_d  = bin;
          cnt_d  = '0;
          res_d  = '0;
        end
      end
      StShift: begin
        diff_bit_d = d_bit;
        valid_d    = 1'b1;
        // New bits enter at the MSB so bit 0 ends up as the LSB after WIDTH shifts
        res_d      = {d_bit, res_q[WIDTH-1:1]};
        a_sh_d     = a_sh_q >> 1;
        b_sh_d     = b_sh_q >> 1;
        brw_d      = brw_nxt;
        cnt_d      = cnt_q + CW'(1);
      end
      StDone: begin
        done_d = 1'b1;
        diff_d = res_q;
        bout_d = brw_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_q      <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      brw_q      <= 1'b0;
      diff_bit_q <= 1'b0;
      valid_q    <= 1'b0;
      bout_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_q      <= res_d;
      diff_q     <= diff_d;
      cnt_q      <= cnt_d;
      brw_q      <= brw_d;
      diff_bit_q <= diff_bit_d;
      valid_q    <= valid_d;
      bout_q     <= bout_d;
      done_q     <= done_d;
    end
  end

  assign diff_bit       = diff_bit_q;
  assign diff_bit_valid = valid_q;
  assign diff           = diff_q;
  assign bout           = bout_q;
  assign done           = done_q;

endmodule
